// File: rtl/inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : inst_encoder
// Description : Packs R/I/J instruction fields into a 32-bit word, tags each
//               word with a running byte address and queues it in a 2-entry
//               FIFO. ERR_T inputs are dropped and counted (sticky err flag,
//               saturating err_cnt).
//               Optional macro ENC_CHECK_EN also drops inputs whose opcode
//               does not belong to the declared instruction type.
// Revision    : 1.0 - initial release
// ============================================================================

`ifndef R_TYPE
`define R_TYPE 2'd0
`endif
`ifndef I_TYPE
`define I_TYPE 2'd1
`endif
`ifndef J_TYPE
`define J_TYPE 2'd2
`endif
`ifndef ERR_T
`define ERR_T 2'd3
`endif
`ifndef OP_WIDTH
`define OP_WIDTH 6
`endif
`ifndef REG_ADDR_W
`define REG_ADDR_W 5
`endif
`ifndef WORD_INDEX_W
`define WORD_INDEX_W 5
`endif
`ifndef FUNCT_WIDTH
`define FUNCT_WIDTH 6
`endif
`ifndef IMM_WIDTH
`define IMM_WIDTH 16
`endif
`ifndef J_ADDR_WIDTH
`define J_ADDR_WIDTH 26
`endif
`ifndef R_R
`define R_R 6'h00
`endif
`ifndef J
`define J 6'h02
`endif
`ifndef LW
`define LW 6'h23
`endif
`ifndef SW
`define SW 6'h2B
`endif
`ifndef BEQ
`define BEQ 6'h04
`endif
`ifndef BNE
`define BNE 6'h05
`endif
`ifndef BLEZ
`define BLEZ 6'h06
`endif
`ifndef BGTZ
`define BGTZ 6'h07
`endif
`ifndef BGEZ_BLTZ
`define BGEZ_BLTZ 6'h01
`endif

module inst_encoder #(
  parameter int          W         = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               inst_type,
  input  logic [`OP_WIDTH-1:0]     op_code,
  input  logic [`REG_ADDR_W-1:0]   rs,
  input  logic [`REG_ADDR_W-1:0]   rt,
  input  logic [`REG_ADDR_W-1:0]   rd,
  input  logic [`WORD_INDEX_W-1:0] shamt,
  input  logic [`FUNCT_WIDTH-1:0]  funct,
  input  logic [`IMM_WIDTH-1:0]    imm,
  input  logic [`J_ADDR_WIDTH-1:0] j_addr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_inst,
  output logic [W-1:0]             out_addr,
  output logic                     err,
  output logic [7:0]               err_cnt
);

  // FIFO is two explicit slots: head (presented on the outputs) and tail.
  logic [1:0]   count_q, count_d;
  logic [W-1:0] head_inst_q, head_inst_d, tail_inst_q, tail_inst_d;
  logic [W-1:0] head_addr_q, head_addr_d, tail_addr_q, tail_addr_d;
  logic [31:0]  addr_q, addr_d;
  logic         err_q, err_d;
  logic [7:0]   err_cnt_q, err_cnt_d;

  logic [31:0]  packed_word;
  logic         type_mismatch;
  logic         accept, drop, push, pop;
  logic [1:0]   count_after_pop;

  assign in_ready  = (count_q < 2'd2) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && out_ready;

  // Field packing selected by the declared instruction type.
  always_comb begin
    packed_word = '0;
    case (inst_type)
      `R_TYPE: packed_word = {op_code, rs, rt, rd, shamt, funct};
      `I_TYPE: packed_word = {op_code, rs, rt, imm};
      `J_TYPE: packed_word = {op_code, j_addr};
      default: packed_word = '0;
    endcase
  end

`ifdef ENC_CHECK_EN
  // Flag opcodes that do not belong to the declared instruction type.
  always_comb begin
    type_mismatch = 1'b0;
    case (inst_type)
      `R_TYPE: type_mismatch = (op_code != `R_R);
      `J_TYPE: type_mismatch = (op_code != `J);
      `I_TYPE: type_mismatch = !(op_code inside {`LW, `SW, `BEQ, `BNE,
                                                 `BLEZ, `BGTZ, `BGEZ_BLTZ});
      default: type_mismatch = 1'b0;
    endcase
  end
`else
  assign type_mismatch = 1'b0;
`endif

  assign drop = accept && ((inst_type == `ERR_T) || type_mismatch);
  assign push = accept && !drop;

  // Next-state: pop shifts tail to head, then a push fills the first free slot.
  always_comb begin
    head_inst_d     = head_inst_q;
    head_addr_d     = head_addr_q;
    tail_inst_d     = tail_inst_q;
    tail_addr_d     = tail_addr_q;
    addr_d          = addr_q;
    err_d           = err_q;
    err_cnt_d       = err_cnt_q;
    count_after_pop = count_q - {1'b0, pop};

    if (pop) begin
      head_inst_d = tail_inst_q;
      head_addr_d = tail_addr_q;
    end

    if (push) begin
      if (count_after_pop == 2'd0) begin
        head_inst_d = W'(packed_word);
        head_addr_d = W'(addr_q);
      end else begin
        tail_inst_d = W'(packed_word);
        tail_addr_d = W'(addr_q);
      end
      addr_d = addr_q + 32'd4;
    end

    count_d = count_after_pop + {1'b0, push};

    if (drop) begin
      err_d = 1'b1;
      if (err_cnt_q != 8'hFF) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  // State registers with synchronous reset that also discards queued words.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q     <= 2'd0;
      head_inst_q <= '0;
      head_addr_q <= '0;
      tail_inst_q <= '0;
      tail_addr_q <= '0;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      err_cnt_q   <= 8'd0;
    end else begin
      count_q     <= count_d;
      head_inst_q <= head_inst_d;
      head_addr_q <= head_addr_d;
      tail_inst_q <= tail_inst_d;
      tail_addr_q <= tail_addr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_inst = head_inst_q;
  assign out_addr = head_addr_q;
  assign err      = err_q;
  assign err_cnt  = err_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_encoder
// Description : Self-checking bench for inst_encoder. Directed spec vectors
//               followed by random traffic, compared cycle by cycle against a
//               queue-based reference model of the encoder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_encoder;

  localparam logic [31:0] TB_BASE = 32'hFFFF_FF00;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  inst_type;
  logic [5:0]  op_code;
  logic [4:0]  rs, rt, rd, shamt;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic [25:0] j_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_addr;
  logic        err;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad   = 0;

  // reference model state
  bit [31:0] q_inst[$];
  bit [31:0] q_addr[$];
  bit [31:0] m_addr;
  bit        m_err;
  int        m_cnt;

  inst_encoder #(.W(32), .BASE_ADDR(TB_BASE)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .inst_type(inst_type),
    .op_code  (op_code),
    .rs       (rs),
    .rt       (rt),
    .rd       (rd),
    .shamt    (shamt),
    .funct    (funct),
    .imm      (imm),
    .j_addr   (j_addr),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_inst (out_inst),
    .out_addr (out_addr),
    .err      (err),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Encoding written as plain field weights (powers of two).
  function automatic bit [31:0] model_word();
    bit [31:0] w;
    case (inst_type)
      2'd0: w = op_code * 32'h0400_0000 + rs * 32'h0020_0000 + rt * 32'h0001_0000
              + rd * 32'h0000_0800 + shamt * 32'h0000_0040 + 32'(funct);
      2'd1: w = op_code * 32'h0400_0000 + rs * 32'h0020_0000 + rt * 32'h0001_0000
              + 32'(imm);
      default: w = op_code * 32'h0400_0000 + 32'(j_addr);
    endcase
    return w;
  endfunction

  function automatic bit model_drop();
    bit d;
    d = (inst_type == 2'd3);
`ifdef ENC_CHECK_EN
    if (inst_type == 2'd0 && op_code != 6'h00) d = 1'b1;
    if (inst_type == 2'd2 && op_code != 6'h02) d = 1'b1;
    if (inst_type == 2'd1 && !(op_code inside {6'h23, 6'h2B, 6'h04, 6'h05,
                                               6'h06, 6'h07, 6'h01})) d = 1'b1;
`endif
    return d;
  endfunction

  function automatic logic [5:0] legal_op(input logic [1:0] t);
    logic [5:0] ops [7];
    ops = '{6'h23, 6'h2B, 6'h04, 6'h05, 6'h06, 6'h07, 6'h01};
    case (t)
      2'd0:    return 6'h00;
      2'd2:    return 6'h02;
      2'd1:    return ops[$urandom_range(0, 6)];
      default: return 6'($urandom);
    endcase
  endfunction

  // One clock: check outputs at the falling edge, advance the model at the rising edge.
  task automatic tick();
    bit do_pop, do_acc;
    @(negedge clk);
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!rst && q_inst.size() < 2)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (q_inst.size() > 0)});
    if (q_inst.size() > 0) begin
      chk("out_inst", out_inst, q_inst[0]);
      chk("out_addr", out_addr, q_addr[0]);
    end
    chk("err", {31'd0, err}, {31'd0, m_err});
    chk("err_cnt", {24'd0, err_cnt}, 32'(m_cnt));
    @(posedge clk);
    if (rst) begin
      q_inst.delete();
      q_addr.delete();
      m_addr = TB_BASE;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else begin
      do_pop = (q_inst.size() > 0) && out_ready;
      do_acc = in_valid && (q_inst.size() < 2);
      if (do_pop) begin
        void'(q_inst.pop_front());
        void'(q_addr.pop_front());
      end
      if (do_acc) begin
        if (model_drop()) begin
          m_err = 1'b1;
          if (m_cnt < 255) m_cnt++;
        end else begin
          q_inst.push_back(model_word());
          q_addr.push_back(m_addr);
          m_addr = m_addr + 32'd4;
        end
      end
    end
    #1;
  endtask

  task automatic set_in(input logic [1:0] t, input logic [5:0] op, input logic [4:0] a_rs,
                        input logic [4:0] a_rt, input logic [4:0] a_rd, input logic [4:0] a_sh,
                        input logic [5:0] a_fn, input logic [15:0] a_imm, input logic [25:0] a_ja);
    in_valid  = 1'b1;
    inst_type = t;
    op_code   = op;
    rs        = a_rs;
    rt        = a_rt;
    rd        = a_rd;
    shamt     = a_sh;
    funct     = a_fn;
    imm       = a_imm;
    j_addr    = a_ja;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_inst", out_inst, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    set_in(2'd0, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    in_valid = 1'b0;
    m_addr = TB_BASE;
    m_err  = 1'b0;
    m_cnt  = 0;

    // reset state
    do_reset();
    tick();

    // R example
    do_reset();
    set_in(2'd0, 6'h00, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0);
    tick();
    in_valid = 1'b0;
    chk("r_word", out_inst, 32'h0022_1820);
    chk("r_addr", out_addr, TB_BASE);
    tick();

    // I then J back to back
    do_reset();
    set_in(2'd1, 6'h23, 5'd29, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0010, 26'd0);
    tick();
    chk("i_word", out_inst, 32'h8FA8_0010);
    chk("i_addr", out_addr, TB_BASE);
    set_in(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h010_0000);
    tick();
    in_valid = 1'b0;
    chk("j_word", out_inst, 32'h0810_0000);
    chk("j_addr", out_addr, TB_BASE + 32'd4);
    tick();

    // backpressure: three pushes with consumer stalled
    do_reset();
    out_ready = 1'b0;
    set_in(2'd0, 6'h00, 5'd1, 5'd1, 5'd1, 5'd1, 6'h21, 16'd0, 26'd0);
    tick();
    set_in(2'd0, 6'h00, 5'd2, 5'd2, 5'd2, 5'd2, 6'h22, 16'd0, 26'd0);
    tick();
    set_in(2'd0, 6'h00, 5'd3, 5'd3, 5'd3, 5'd3, 6'h23, 16'd0, 26'd0);
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    tick();
    in_valid = 1'b0;
    chk("third_addr", out_addr, TB_BASE + 32'd8);
    tick();
    tick();

    // ERR_T drop leaves address unadvanced
    do_reset();
    set_in(2'd3, 6'h3F, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h1234, 26'h1);
    tick();
    in_valid = 1'b0;
    chk("drop_valid", {31'd0, out_valid}, 32'd0);
    chk("drop_err", {31'd0, err}, 32'd1);
    chk("drop_cnt", {24'd0, err_cnt}, 32'd1);
    set_in(2'd0, 6'h00, 5'd4, 5'd5, 5'd6, 5'd7, 6'h2A, 16'd0, 26'd0);
    tick();
    in_valid = 1'b0;
    chk("after_drop_addr", out_addr, TB_BASE);
    tick();

    // R_TYPE with load opcode
    do_reset();
    set_in(2'd0, 6'h23, 5'd1, 5'd2, 5'd3, 5'd4, 6'h05, 16'd0, 26'd0);
    tick();
    in_valid = 1'b0;
`ifdef ENC_CHECK_EN
    chk("mismatch_cnt", {24'd0, err_cnt}, 32'd1);
    chk("mismatch_valid", {31'd0, out_valid}, 32'd0);
`else
    chk("mismatch_word", out_inst, 32'h8C00_0000 | 32'h0022_1905);
`endif
    tick();

    // two words queued, then reset mid-operation
    do_reset();
    out_ready = 1'b0;
    set_in(2'd1, 6'h2B, 5'd7, 5'd9, 5'd0, 5'd0, 6'd0, 16'hBEEF, 26'd0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_err", {24'd0, err_cnt}, 32'd0);
    out_ready = 1'b1;
    set_in(2'd2, 6'h02, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h3FF_FFFF);
    tick();
    in_valid = 1'b0;
    chk("midrst_addr", out_addr, TB_BASE);
    tick();

    // random traffic (address counter wraps past 2^32)
    for (int i = 0; i < 600; i++) begin
      logic [1:0] t;
      t = 2'($urandom_range(0, 3));
      set_in(t, ($urandom_range(0, 3) != 0) ? legal_op(t) : 6'($urandom),
             5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
             6'($urandom), 16'($urandom), 26'($urandom));
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      rst       = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0;

    // error counter saturation
    out_ready = 1'b1;
    set_in(2'd3, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0);
    for (int i = 0; i < 260; i++) tick();
    in_valid = 1'b0;
    chk("sat_cnt", {24'd0, err_cnt}, 32'd255);
    chk("sat_err", {31'd0, err}, 32'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter W, default 32, meaning instruction word width.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000, meaning byte address of the first emitted word.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  input field set valid.
REQ-006 SHALL have port in_ready  output  1  encoder can accept.
REQ-007 SHALL have port inst_type  input  2  `R_TYPE/`I_TYPE/`J_TYPE/`ERR_T.
REQ-008 SHALL have port op_code  input  `OP_WIDTH (6)  opcode.
REQ-009 SHALL have ports rs, rt, rd  input  `REG_ADDR_W (5) each  register fields.
REQ-010 SHALL have port shamt  input  `WORD_INDEX_W (5)  shift amount.
REQ-011 SHALL have port funct  input  `FUNCT_WIDTH (6)  R function code.
REQ-012 SHALL have port imm  input  `IMM_WIDTH (16)  I immediate.
REQ-013 SHALL have port j_addr  input  `J_ADDR_WIDTH (26)  J target field.
REQ-014 SHALL have port out_valid  output  1  head entry valid.
REQ-015 SHALL have port out_ready  input  1  consumer accepts head.
REQ-016 SHALL have port out_inst  output  W  encoded word of head entry.
REQ-017 SHALL have port out_addr  output  W  byte address of head entry.
REQ-018 SHALL have ports err (output, 1, sticky drop flag) and err_cnt (output, 8, dropped-input count).

Function
REQ-019 SHALL accept an input on a posedge where in_valid && in_ready; in_ready = (fifo count < 2) && !rst, combinational.
REQ-020 SHALL pack R as {op_code,rs,rt,rd,shamt,funct}, I as {op_code,rs,rt,imm}, J as {op_code,j_addr}.
REQ-021 SHALL drop accepted `ERR_T inputs: no FIFO push, no address advance, err<=1, err_cnt increments.
REQ-022 SHALL push each non-dropped word with the current address into a 2-entry FIFO; the address counter then advances by 4, wrapping modulo 2^32.
REQ-023 SHALL present the pushed word with out_valid=1 in the cycle after acceptance (latency 1); no input-to-output bypass.
REQ-024 SHALL pop head on a posedge where out_valid && out_ready; FIFO order preserved.
REQ-025 SHALL, on simultaneous push and pop, leave count unchanged with correct ordering; at count 2 in_ready=0, so no push occurs.
REQ-026 SHALL hold out_inst/out_addr stable while out_valid && !out_ready.
REQ-027 SHALL saturate err_cnt at 255; err stays 1 until reset.

Reset
REQ-028 SHALL on rst: FIFO empty, out_valid=0, out_inst=0, out_addr=0, address counter=BASE_ADDR, err=0, err_cnt=0.
REQ-029 SHALL discard FIFO contents when rst asserts mid-operation; no input accepted in a reset cycle.

Configuration
REQ-030 SHALL, with ENC_CHECK_EN defined, additionally drop (per REQ-021) inputs whose op_code disagrees with inst_type: R needs `R_R; J needs `J; I needs one of `LW,`SW,`BEQ,`BNE,`BLEZ,`BGTZ,`BGEZ_BLTZ.
REQ-031 SHALL, without ENC_CHECK_EN, pack by inst_type alone; only `ERR_T is dropped.

Verification
REQ-032 R: op 0,rs 1,rt 2,rd 3,shamt 0,funct 0x20 -> next cycle out_inst=0x00221820, out_addr=BASE_ADDR.
REQ-033 I then J back-to-back: op 0x23,rs 29,rt 8,imm 0x0010 -> 0x8FA80010 @BASE; op 2,j_addr 0x0100000 -> 0x08100000 @BASE+4.
REQ-034 out_ready=0, three valid pushes -> in_ready=0 after two, third held; out_ready=1 -> words emerge in order, addresses +0,+4,+8.
REQ-035 `ERR_T input -> no output, err=1, err_cnt=1, next valid word keeps unadvanced address; 256 drops -> err_cnt=255.
REQ-036 ENC_CHECK_EN: R_TYPE with op 0x23 -> dropped, err_cnt=1; without macro -> out_inst=0x8C000000 | low fields.
REQ-037 Two words queued, rst for 1 cycle -> out_valid=0, next accepted word at BASE_ADDR, err/err_cnt=0.
